// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the pipeline CPU's MEM stage.
// It holds a word-addressed RAM and a 16-byte MMIO page. The page contains a
// cycle counter, a TX FIFO with a valid/ready drain port, and a status register.
// Read data is combinational so the CPU can sample it in the same cycle.

module dmem_mmio_responder #(
    parameter int unsigned RAM_ADDR_WIDTH  = 10,
    parameter int unsigned FIFO_DEPTH_LOG2 = 3,
    parameter logic [31:0] MMIO_BASE       = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cnt_ena,
    input  logic [31:0] DMEM_addr,
    input  logic [31:0] DMEM_wdata,
    input  logic        DMEM_we,
    output logic [31:0] DMEM_rdata,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready
);

    localparam int unsigned RAM_DEPTH  = 2 ** RAM_ADDR_WIDTH;
    localparam int unsigned FIFO_DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam int unsigned PW         = FIFO_DEPTH_LOG2 + 1;

    localparam logic [1:0] REG_CYCLE  = 2'd0;
    localparam logic [1:0] REG_TXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

    // State
    logic [31:0]   r_ram      [0:RAM_DEPTH-1];
    logic [31:0]   r_fifo_mem [0:FIFO_DEPTH-1];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [31:0]   r_cycle;
    logic          r_ovf;
    logic          r_fault;

    // Decode and control
    logic                       w_ram_hit;
    logic                       w_mmio_hit;
    logic [RAM_ADDR_WIDTH-1:0]  w_word_idx;
    logic [1:0]                 w_reg_sel;
    logic                       w_wr_cycle;
    logic                       w_wr_txdata;
    logic                       w_wr_status;
    logic                       w_wr_unmapped;
    logic                       w_empty;
    logic                       w_full;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_ovf_set;
    logic                       w_ovf_clr;
    logic                       w_fault_clr;
    logic [PW-1:0]              w_count;
    logic [7:0]                 w_occ;
    logic [31:0]                w_status;
    logic [31:0]                w_head;
    logic                       w_unused_addr_bits;

    // Byte lane bits are meaningless for word-only access
    assign w_unused_addr_bits = &{1'b0, DMEM_addr[1:0]};

    assign w_ram_hit  = (DMEM_addr[31:RAM_ADDR_WIDTH+2] == {(32-RAM_ADDR_WIDTH-2){1'b0}});
    assign w_mmio_hit = (DMEM_addr[31:4] == MMIO_BASE[31:4]);
    assign w_word_idx = DMEM_addr[RAM_ADDR_WIDTH+1:2];
    assign w_reg_sel  = DMEM_addr[3:2];

    assign w_wr_cycle    = DMEM_we && w_mmio_hit && (w_reg_sel == REG_CYCLE);
    assign w_wr_txdata   = DMEM_we && w_mmio_hit && (w_reg_sel == REG_TXDATA);
    assign w_wr_status   = DMEM_we && w_mmio_hit && (w_reg_sel == REG_STATUS);
    assign w_wr_unmapped = DMEM_we && !w_ram_hit && !w_mmio_hit;

    // Pointer MSB distinguishes the full wrap from the empty case
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_occ   = {{(8-PW){1'b0}}, w_count};

    // Full-drop uses pre-edge state, so a concurrent pop cannot rescue the push
    assign w_push      = w_wr_txdata && !w_full;
    assign w_pop       = tx_valid && tx_ready;
    assign w_ovf_set   = w_wr_txdata && w_full;
    assign w_ovf_clr   = w_wr_status && DMEM_wdata[2];
    assign w_fault_clr = w_wr_status && DMEM_wdata[3];

    assign w_head   = r_fifo_mem[r_rd_ptr[PW-2:0]];
    assign tx_valid = !w_empty;
    assign tx_data  = w_head;

    assign w_status = {16'h0000, w_occ, 4'h0, r_fault, r_ovf, w_full, w_empty};

    // RAM store port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (DMEM_we && w_ram_hit) begin
            r_ram[w_word_idx] <= DMEM_wdata;
        end
    end

    // FIFO storage write on accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr[PW-2:0]] <= DMEM_wdata;
        end
    end

    // FIFO read/write pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

    // Cycle counter; a CPU store overrides the increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle <= 32'h0000_0000;
        end else if (w_wr_cycle) begin
            r_cycle <= DMEM_wdata;
        end else if (cnt_ena) begin
            r_cycle <= r_cycle + 32'd1;
        end else begin
            r_cycle <= r_cycle;
        end
    end

    // Sticky status bits; a set event beats a write-1-to-clear in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf   <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
            if (w_wr_unmapped) begin
                r_fault <= 1'b1;
            end else if (w_fault_clr) begin
                r_fault <= 1'b0;
            end else begin
                r_fault <= r_fault;
            end
        end
    end

    // Zero-latency read mux; returns pre-edge values during a same-cycle store
    always_comb begin
        DMEM_rdata = 32'h0000_0000;
        if (w_ram_hit) begin
            DMEM_rdata = r_ram[w_word_idx];
        end else if (w_mmio_hit) begin
            case (w_reg_sel)
                REG_CYCLE:  DMEM_rdata = r_cycle;
                REG_TXDATA: begin
                    if (w_empty) begin
                        DMEM_rdata = 32'h0000_0000;
                    end else begin
                        DMEM_rdata = w_head;
                    end
                end
                REG_STATUS: DMEM_rdata = w_status;
                REG_RSVD:   DMEM_rdata = 32'h0000_0000;
                default:    DMEM_rdata = 32'h0000_0000;
            endcase
        end else begin
            DMEM_rdata = 32'h0000_0000;
        end
    end

endmodule
